// File: rtl/led_ctrl_pkg.sv
// LED controller shared types and default parameters.
// Mode encoding matches the cfg_mode port field.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

  localparam int DEF_NUM_LEDS = 4;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_TICK_DIV = 100_000;

endpackage

// File: rtl/led_channel.sv
// One LED channel: blink phase, breathe level FSM and the
// registered LED output for its selected mode.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                load,
  input  mode_e               mode,
  input  logic [15:0]         period,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  mode_e               mode_q, mode_d;
  br_state_e           state_q, state_d;
  logic [15:0]         period_q, period_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                phase_q, phase_d;
  logic                last;
  logic                led_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= MODE_OFF;
      state_q  <= BR_UP;
      period_q <= 16'd1;
      cnt_q    <= '0;
      duty_q   <= '0;
      level_q  <= '0;
      phase_q  <= 1'b0;
      led      <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      led      <= led_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    level_d  = level_q;
    phase_d  = phase_q;
    last     = (cnt_q == period_q - 16'd1);
    // a write wins over a coincident tick
    if (load) begin
      mode_d   = mode;
      period_d = (period == 16'd0) ? 16'd1 : period;
      duty_d   = duty;
      cnt_d    = '0;
      phase_d  = 1'b1;
      level_d  = '0;
      state_d  = BR_UP;
    end else if (tick) begin
      unique case (mode_q)
        MODE_BLINK: begin
          if (last) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        MODE_BREATHE: begin
          if (last) begin
            cnt_d = '0;
            unique case (state_q)
              BR_UP: begin
                if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                if (level_d == LVL_MAX) state_d = BR_DOWN;
              end
              BR_DOWN: begin
                if (level_q != '0) level_d = level_q - 1'b1;
                if (level_d == '0) state_d = BR_UP;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        MODE_OFF, MODE_ON: ;
      endcase
    end
  end

  always_comb begin
    led_d = 1'b0;
    unique case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = (duty_q == LVL_MAX) || (pwm_cnt < duty_q);
      MODE_BLINK:   led_d = phase_q;
      MODE_BREATHE: led_d = (pwm_cnt < level_q);
    endcase
  end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: tick prescaler, shared PWM
// counter and config write decode feeding per-channel logic.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  localparam int CH_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                accept;
  logic [NUM_LEDS-1:0] load;

  assign tick   = (presc == PS_LAST);
  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      cfg_ready <= 1'b1;
    end
  end

  // out-of-range channel indices match no slot and are dropped
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    assign load[i] = accept && (cfg_chan == CH_W'(i));

    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .load    (load[i]),
      .mode    (mode_e'(cfg_mode)),
      .period  (cfg_period),
      .duty    (cfg_duty),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4: number of independent LED channels, range 1..16.
REQ-002 SHALL have parameter PWM_BITS, default 8: brightness resolution; the PWM frame is 2^PWM_BITS clk cycles.
REQ-003 SHALL have parameter TICK_DIV, default 100_000: clk cycles per timebase tick, giving 1 kHz at a 100 MHz clk; range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset; synchronous and active-low.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-007 SHALL have port cfg_ready, output, 1 bit: the block can accept a write.
REQ-008 SHALL have port cfg_chan, input, CH_W = max(1,$clog2(NUM_LEDS)) bits: target channel index.
REQ-009 SHALL have port cfg_mode, input, 2 bits: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-010 SHALL have port cfg_period, input, 16 bits: number of ticks per blink half-period or per breathe step.
REQ-011 SHALL have port cfg_duty, input, PWM_BITS bits: brightness used in ON mode.
REQ-012 SHALL have port led, output, NUM_LEDS bits: registered LED drive, one bit per channel.

Function
REQ-013 SHALL run a prescaler that counts 0..TICK_DIV-1 and asserts an internal tick for exactly one cycle on wrap.
REQ-014 SHALL run a shared free-running PWM counter pwm_cnt of PWM_BITS bits that wraps from max to 0.
REQ-015 SHALL accept a write on any cycle where cfg_valid && cfg_ready; cfg_ready SHALL be 1 on every cycle from the first cycle after reset release.
REQ-016 SHALL ignore (drop) an accepted write with cfg_chan >= NUM_LEDS; no channel state changes.
REQ-017 SHALL, on an accepted write, load the channel's mode/period/duty and clear its tick count; effective period = max(cfg_period,1).
REQ-018 SHALL give priority to the write over a coincident tick on the same channel; that tick is not counted.
REQ-019 SHALL latch led with one cycle latency: led reflects the state after edge N at edge N+1.
REQ-020 SHALL drive led=0 in OFF mode.
REQ-021 SHALL drive, in ON mode, led = (pwm_cnt < duty), except that duty = all-ones forces led = 1 constantly.
REQ-022 SHALL, in BLINK mode, set phase=1 on load, increment the count per tick, and on count == period-1 toggle phase and clear the count; led = phase.
REQ-023 SHALL, in BREATHE mode, run an FSM with states UP/DOWN; on load set level=0 and state UP; on count == period-1 clear the count and step level.
REQ-024 SHALL step level as follows: in UP, level+1, moving to DOWN when level reaches all-ones; in DOWN, level-1, moving to UP when level reaches 0. Level SHALL never wrap. led = (pwm_cnt < level).
REQ-025 SHALL keep each channel independent; a write to one channel SHALL NOT disturb the others.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, clear the prescaler, pwm_cnt and all channel counts/levels, set every mode to OFF and FSM state to UP, and drive led=0 and cfg_ready=0.
REQ-027 SHALL treat rst_n low mid-operation identically; no stale phase SHALL survive, and led=0 from the next edge.

Structure
REQ-028 SHALL place the mode enum (OFF/ON/BLINK/BREATHE), the breathe state enum and the default parameter constants in package led_ctrl_pkg.
REQ-029 SHALL implement per-channel count/phase/level/FSM in sub-module led_channel, instantiated NUM_LEDS times via generate; the prescaler, pwm_cnt and write decode stay in led_ctrl.

Verification (bench: TICK_DIV=4, PWM_BITS=4, NUM_LEDS=3, clk period 10 ns)
REQ-030 SHALL verify reset: rst_n=0 for 3 cycles -> led=000 and cfg_ready=0; after release cfg_ready=1 on the next cycle.
REQ-031 SHALL verify ON: ch0 ON duty=15 -> led[0]=1 constantly; ch0 ON duty=4 -> led[0] high exactly 4 of every 16 cycles.
REQ-032 SHALL verify BLINK: ch1 BLINK period=3 -> led[1]=1 one cycle after accept, then toggles every 12 clk cycles, with ch0 unaffected.
REQ-033 SHALL verify BREATHE: ch2 BREATHE period=1 -> level ramps 0..15..0 over 30 ticks (120 clk) and repeats, never wrapping.
REQ-034 SHALL verify write rules: a write with cfg_chan=3 -> no change; a write coincident with a tick -> the count restarts at 0.
REQ-035 SHALL verify reset mid-BLINK: rst_n=0 while led[1]=1 -> led=000 next edge and all modes OFF after release.
